// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
// Optional watchdog is enabled with the RST_SEQ_WDOG_EN macro.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    localparam int unsigned DEF_STAGES       = 4;
    localparam int unsigned DEF_HOLD_CYCLES  = 16;
    localparam int unsigned DEF_DEBOUNCE     = 4;
    localparam int unsigned DEF_STAGE_DLY    = 8;
    localparam int unsigned DEF_CNT_W        = 16;
    localparam int unsigned DEF_WDOG_TIMEOUT = 1024;

    // Width needed to hold the largest of three terminal counts.
    function automatic int unsigned cnt_w_for(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_debounce.sv
// Consecutive-high counter: done_o flags the N-th consecutive high sample.
// Used for PLL lock debounce and (with RST_SEQ_WDOG_EN) the watchdog.
module rst_seq_debounce
    import rst_seq_pkg::*;
#(
    parameter int unsigned N     = DEF_DEBOUNCE,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic in_i,
    output logic done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !in_i) begin
            cnt_d = '0;
        end else if (cnt_q < LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = !clr_i && in_i && (cnt_q >= LAST);

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release after hold, PLL lock debounce and per-stage delay.
// Optional watchdog (WDOG_TIMEOUT, wdog_kick, wdog_fired) via RST_SEQ_WDOG_EN.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned STAGES      = DEF_STAGES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE,
    parameter int unsigned STAGE_DLY   = DEF_STAGE_DLY,
    parameter int unsigned CNT_W       = DEF_CNT_W
`ifdef RST_SEQ_WDOG_EN
    ,
    parameter int unsigned WDOG_TIMEOUT = DEF_WDOG_TIMEOUT
`endif
) (
    input  logic              clk_100m,
    input  logic              sys_rst_n,
    input  logic              pll_locked,
    input  logic              soft_rst_req,
    output logic              soft_rst_ack,
    output logic [STAGES-1:0] stage_rst_n,
    output logic              init_done,
`ifdef RST_SEQ_WDOG_EN
    input  logic              wdog_kick,
    output logic              wdog_fired,
`endif
    output logic              lock_lost
);

    localparam logic [STAGES-1:0] ONE      = STAGES'(1);
    localparam logic [CNT_W-1:0]  HOLD_END = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DLY_END  = CNT_W'(STAGE_DLY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAGES-1:0]  stage_q, stage_d;
    logic               done_q, done_d;
    logic               ack_q, ack_d;
    logic               lost_q, lost_d;
    logic               lock_done;
    logic               abort;

    rst_seq_debounce #(
        .N     (DEBOUNCE),
        .CNT_W (CNT_W)
    ) u_lock_db (
        .clk_i  (clk_100m),
        .rst_ni (sys_rst_n),
        .clr_i  (state_q != ST_WAIT_LOCK),
        .in_i   (pll_locked),
        .done_o (lock_done)
    );

`ifdef RST_SEQ_WDOG_EN
    localparam int unsigned WDOG_W = cnt_w_for(WDOG_TIMEOUT, 1, 1);

    logic fired_q, fired_d;
    logic wdog_done;

    // Counts consecutive un-kicked RUN cycles; held clear outside RUN.
    rst_seq_debounce #(
        .N     (WDOG_TIMEOUT),
        .CNT_W (WDOG_W)
    ) u_wdog (
        .clk_i  (clk_100m),
        .rst_ni (sys_rst_n),
        .clr_i  (state_q != ST_RUN),
        .in_i   (!wdog_kick),
        .done_o (wdog_done)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        done_d  = done_q;
        ack_d   = ack_q && soft_rst_req;
        lost_d  = lost_q;
        abort   = 1'b0;
`ifdef RST_SEQ_WDOG_EN
        fired_d = fired_q;
`endif
        case (state_q)
            ST_HOLD: begin
                if (cnt_q >= HOLD_END) begin
                    if (!soft_rst_req) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_done) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (!pll_locked) begin
                    abort  = 1'b1;
                    lost_d = 1'b1;
                end else if (cnt_q == DLY_END) begin
                    cnt_d   = '0;
                    stage_d = (stage_q << 1) | ONE;
                    if (stage_d[STAGES-1]) begin
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!pll_locked) begin
                    abort  = 1'b1;
                    lost_d = 1'b1;
                end
                if (soft_rst_req) begin
                    abort = 1'b1;
                    ack_d = 1'b1;
                end
`ifdef RST_SEQ_WDOG_EN
                if (wdog_done) begin
                    abort   = 1'b1;
                    fired_d = 1'b1;
                end
`endif
            end
            default: state_d = ST_HOLD;
        endcase

        // Every reset cause funnels into one return to HOLD with all stages asserted.
        if (abort) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            stage_d = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_100m) begin
        if (!sys_rst_n) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            lost_q  <= lost_d;
        end
    end

`ifdef RST_SEQ_WDOG_EN
    always_ff @(posedge clk_100m) begin
        if (!sys_rst_n) begin
            fired_q <= 1'b0;
        end else begin
            fired_q <= fired_d;
        end
    end

    assign wdog_fired = fired_q;
`endif

    assign stage_rst_n  = stage_q;
    assign init_done    = done_q;
    assign soft_rst_ack = ack_q;
    assign lock_lost    = lost_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer against a timestamp-based reference model.
// Watchdog checks compile in when RST_SEQ_WDOG_EN is defined.
module tb_rst_sequencer;

    localparam int ST = 4;
    localparam int HC = 16;
    localparam int DB = 4;
    localparam int SD = 8;
    localparam int WT = 20;

    logic          clk;
    logic          sys_rst_n;
    logic          pll_locked;
    logic          soft_rst_req;
    logic          soft_rst_ack;
    logic [ST-1:0] stage_rst_n;
    logic          init_done;
    logic          lock_lost;
    logic          kick;
`ifdef RST_SEQ_WDOG_EN
    logic          wdog_fired;
`endif

    rst_sequencer #(
        .STAGES      (ST),
        .HOLD_CYCLES (HC),
        .DEBOUNCE    (DB),
        .STAGE_DLY   (SD),
        .CNT_W       (16)
`ifdef RST_SEQ_WDOG_EN
        ,
        .WDOG_TIMEOUT(WT)
`endif
    ) dut (
        .clk_100m     (clk),
        .sys_rst_n    (sys_rst_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .soft_rst_ack (soft_rst_ack),
        .stage_rst_n  (stage_rst_n),
        .init_done    (init_done),
`ifdef RST_SEQ_WDOG_EN
        .wdog_kick    (kick),
        .wdog_fired   (wdog_fired),
`endif
        .lock_lost    (lock_lost)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    // Reference model: timestamps of the last HOLD entry and release start.
    int m_hold_from, m_rel_from, m_lock_cnt, m_wd;
    bit m_waiting, m_lost, m_ack, m_fired;

    function automatic int rel_count(input int at);
        int n;
        if (m_rel_from < 0) return 0;
        n = (at - m_rel_from) / SD;
        return (n > ST) ? ST : n;
    endfunction

    task automatic model_edge(input logic r, input logic l, input logic q, input logic k);
        bit running, abrt;
        if (!r) begin
            m_hold_from = t; m_rel_from = -1; m_waiting = 0; m_lock_cnt = 0;
            m_lost = 0; m_ack = 0; m_wd = 0; m_fired = 0;
            return;
        end
        if (!q) m_ack = 0;
        if (m_rel_from >= 0) begin
            running = (rel_count(t - 1) == ST);
            abrt = 0;
            if (!l) begin abrt = 1; m_lost = 1; end
            if (running && q) begin abrt = 1; m_ack = 1; end
`ifdef RST_SEQ_WDOG_EN
            if (running) begin
                m_wd = k ? 0 : m_wd + 1;
                if (m_wd >= WT) begin abrt = 1; m_fired = 1; end
            end else begin
                m_wd = 0;
            end
`else
            if (k) m_wd = 0;
`endif
            if (abrt) begin m_hold_from = t; m_rel_from = -1; m_wd = 0; end
        end else if (m_waiting) begin
            m_lock_cnt = l ? m_lock_cnt + 1 : 0;
            if (m_lock_cnt == DB) begin m_rel_from = t; m_waiting = 0; end
        end else if ((t - m_hold_from) >= HC && !q) begin
            m_waiting = 1; m_lock_cnt = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic q);
        int n;
        sys_rst_n = r; pll_locked = l; soft_rst_req = q;
        @(posedge clk);
        t++;
        model_edge(r, l, q, kick);
        #1;
        n = rel_count(t);
        chk("stage_rst_n", 32'(stage_rst_n), 32'((1 << n) - 1));
        chk("init_done", 32'(init_done), 32'(n == ST));
        chk("lock_lost", 32'(lock_lost), 32'(m_lost));
        chk("soft_rst_ack", 32'(soft_rst_ack), 32'(m_ack));
`ifdef RST_SEQ_WDOG_EN
        chk("wdog_fired", 32'(wdog_fired), 32'(m_fired));
`endif
    endtask

    initial begin
        int e0, first, n;
        bit lk, rq, hit;
        clk = 0; kick = 0;
        sys_rst_n = 0; pll_locked = 0; soft_rst_req = 0;

        // Reset state, then power-up with lock held high.
        repeat (3) cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        e0 = t; first = -1;
        repeat (70) begin
            cyc(1, 1, 0);
            if (init_done === 1'b1 && first < 0) first = t - e0;
        end
        chk("powerup_done_edge", 32'(first), 32'd52);

        // One-cycle lock loss in RUN, then full restart; lock_lost stays set.
        cyc(1, 0, 0);
        chk("lock_loss_cleared", 32'(stage_rst_n), 32'd0);
        repeat (60) cyc(1, 1, 0);

        // Software request in RUN for a random number of cycles.
        repeat (2) cyc(0, 1, 0);
        repeat (56) cyc(1, 1, 0);
        n = $urandom_range(1, 12);
        repeat (n) cyc(1, 1, 1);
        repeat (60) cyc(1, 1, 0);

        // Lock glitch at edge 18 during WAIT_LOCK shifts release by two cycles.
        repeat (2) cyc(0, 1, 0);
        e0 = t; first = -1;
        for (int k = 1; k <= 60; k++) begin
            cyc(1, (k == 18) ? 1'b0 : 1'b1, 0);
            if (init_done === 1'b1 && first < 0) first = t - e0;
        end
        chk("wait_glitch_done_edge", 32'(first), 32'd54);
        chk("wait_glitch_no_lost", 32'(lock_lost), 32'd0);

        // Lock loss right after the second stage releases.
        repeat (2) cyc(0, 1, 0);
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            cyc(1, 1, 0);
            if (stage_rst_n === 4'b0011) hit = 1;
        end
        chk("reached_0011", 32'(hit), 32'd1);
        cyc(1, 0, 0);
        chk("partial_release_cleared", 32'(stage_rst_n), 32'd0);
        repeat (30) cyc(1, 1, 0);

        // Soft request during RELEASE is ignored; then simultaneous loss and request in RUN.
        repeat (2) cyc(0, 1, 0);
        repeat (30) cyc(1, 1, 0);
        repeat (2) cyc(1, 1, 1);
        repeat (40) cyc(1, 1, 0);
        cyc(1, 0, 1);
        chk("both_causes_ack", 32'(soft_rst_ack), 32'd1);
        chk("both_causes_lost", 32'(lock_lost), 32'd1);
        repeat (3) cyc(1, 1, 1);
        repeat (60) cyc(1, 1, 0);

        // Reset asserted mid-sequence.
        repeat (2) cyc(0, 1, 0);
        repeat ($urandom_range(20, 50)) cyc(1, 1, 0);
        cyc(0, 1, 0);
        chk("mid_reset_stages", 32'(stage_rst_n), 32'd0);

        // Randomised traffic.
        rq = 0;
        repeat (500) begin
            lk = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 14) == 0) rq = ~rq;
            cyc(($urandom_range(0, 299) != 0), lk, rq);
        end

`ifdef RST_SEQ_WDOG_EN
        // No kicks in RUN fires the watchdog; periodic kicks never do.
        repeat (2) cyc(0, 1, 0);
        repeat (80) cyc(1, 1, 0);
        chk("wdog_fired_no_kick", 32'(wdog_fired), 32'd1);
        repeat (2) cyc(0, 1, 0);
        repeat (52) cyc(1, 1, 0);
        for (int k = 0; k < 100; k++) begin
            kick = (k % 10 == 9);
            cyc(1, 1, 0);
        end
        kick = 0;
        chk("wdog_quiet_with_kicks", 32'(wdog_fired), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
